// File: rtl/ccpu_pkg.sv
// Shared CPU datapath widths, reset vector and ALU B-operand source decode.
package ccpu_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] RESET_VEC = 16'h0000;

    typedef enum logic [1:0] {
        AluSelNone,
        AluSelLo,
        AluSelHi,
        AluSelBoth
    } alu_sel_e;

    // Both output enables are active-low.
    function automatic alu_sel_e alu_sel_decode(input logic oe_pl_n, input logic oe_ph_n);
        alu_sel_e sel;
        unique case ({oe_ph_n, oe_pl_n})
            2'b11:   sel = AluSelNone;
            2'b10:   sel = AluSelLo;
            2'b01:   sel = AluSelHi;
            default: sel = AluSelBoth;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/pointer_unit_if.sv
// Control, data and address signals between the control unit and the pointer unit.
interface pointer_unit_if;
    import ccpu_pkg::*;

    logic [DATA_W-1:0] di;
    logic              ip_inc;
    logic              swap_p;
    logic              we_pl;
    logic              we_ph;
    logic              addr_dp;
    logic              oe_pl_alu;
    logic              oe_ph_alu;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] alu_b;
    logic              alu_b_en;
    logic [ADDR_W-1:0] ip;
    logic [ADDR_W-1:0] dp;

    modport master (
        output di, ip_inc, swap_p, we_pl, we_ph, addr_dp, oe_pl_alu, oe_ph_alu,
        input  addr, alu_b, alu_b_en, ip, dp
    );

    modport slave (
        input  di, ip_inc, swap_p, we_pl, we_ph, addr_dp, oe_pl_alu, oe_ph_alu,
        output addr, alu_b, alu_b_en, ip, dp
    );

endinterface

// File: rtl/ptr_incr.sv
// 16-bit wrap-around incrementer shared by plain IP increment and swap-with-return.
module ptr_incr
    import ccpu_pkg::*;
(
    input  logic [ADDR_W-1:0] i_val,
    output logic [ADDR_W-1:0] o_val
);

    assign o_val = i_val + ADDR_W'(1);

endmodule

// File: rtl/pointer_unit.sv
// IP/DP pointer register pair with address mux, DP byte loads and ALU B-operand drive.
module pointer_unit
    import ccpu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    pointer_unit_if.slave bus
);

    logic [ADDR_W-1:0] r_ip;
    logic [ADDR_W-1:0] r_dp;
    logic [ADDR_W-1:0] w_ip_inc;
    alu_sel_e          w_alu_sel;

    ptr_incr u_ptr_incr (
        .i_val (r_ip),
        .o_val (w_ip_inc)
    );

    // Swap takes priority and drops byte writes; with ip_inc it leaves the return address in DP.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_ip <= RESET_VEC;
            r_dp <= RESET_VEC;
        end else if (bus.swap_p) begin
            r_ip <= r_dp;
            r_dp <= bus.ip_inc ? w_ip_inc : r_ip;
        end else begin
            if (bus.ip_inc) begin
                r_ip <= w_ip_inc;
            end
            if (!bus.we_pl) begin
                r_dp[DATA_W-1:0] <= bus.di;
            end
            if (!bus.we_ph) begin
                r_dp[ADDR_W-1:DATA_W] <= bus.di;
            end
        end
    end

    assign w_alu_sel = alu_sel_decode(bus.oe_pl_alu, bus.oe_ph_alu);

    always_comb begin
        bus.alu_b    = '0;
        bus.alu_b_en = 1'b0;
        unique case (w_alu_sel)
            AluSelLo: begin
                bus.alu_b    = r_dp[DATA_W-1:0];
                bus.alu_b_en = 1'b1;
            end
            AluSelHi: begin
                bus.alu_b    = r_dp[ADDR_W-1:DATA_W];
                bus.alu_b_en = 1'b1;
            end
            AluSelBoth: begin
                bus.alu_b    = r_dp[DATA_W-1:0] | r_dp[ADDR_W-1:DATA_W];
                bus.alu_b_en = 1'b1;
            end
            default: begin
                bus.alu_b    = '0;
                bus.alu_b_en = 1'b0;
            end
        endcase
    end

    assign bus.addr = bus.addr_dp ? r_dp : r_ip;
    assign bus.ip   = r_ip;
    assign bus.dp   = r_dp;

endmodule

// File: doc/pointer_unit.md
POINTER_UNIT -- requirements
Module: pointer_unit

Interface
REQ-001 SHALL have port clk, input, 1: single CPU clock; all state updates on falling edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port di, input, 8: internal data bus, source for DP byte loads.
REQ-004 SHALL have port ip_inc, input, 1: active-high, increment IP at next falling edge.
REQ-005 SHALL have port swap_p, input, 1: active-high, exchange IP and DP at next falling edge.
REQ-006 SHALL have port we_pl, input, 1: active-low, latch di into DP[7:0].
REQ-007 SHALL have port we_ph, input, 1: active-low, latch di into DP[15:8].
REQ-008 SHALL have port addr_dp, input, 1: address select, 0 = IP, 1 = DP.
REQ-009 SHALL have port oe_pl_alu, input, 1: active-low, drive DP[7:0] onto ALU B operand.
REQ-010 SHALL have port oe_ph_alu, input, 1: active-low, drive DP[15:8] onto ALU B operand.
REQ-011 SHALL have port addr, output, 16: memory address bus.
REQ-012 SHALL have port alu_b, output, 8: ALU B operand contribution.
REQ-013 SHALL have port alu_b_en, output, 1: active-high, alu_b valid and this block owns the operand.
REQ-014 SHALL have port ip, output, 16 and port dp, output, 16: debug visibility of registers.

Function
REQ-015 SHALL hold two 16-bit registers, IP and DP, updated only on falling clk edge or reset.
REQ-016 SHALL drive addr combinationally: DP when addr_dp = 1, else IP; no added latency.
REQ-017 SHALL increment IP by 1 modulo 2^16 when ip_inc = 1 and swap_p = 0; 0xFFFF wraps to 0x0000.
REQ-018 SHALL, when swap_p = 1 and ip_inc = 0, set IP <= old DP and DP <= old IP in one edge.
REQ-019 SHALL, when swap_p = 1 and ip_inc = 1, set IP <= old DP and DP <= old IP + 1 (wrapped), leaving return address in DP.
REQ-020 SHALL load DP[7:0] from di when we_pl = 0 and DP[15:8] from di when we_ph = 0, only when swap_p = 0.
REQ-021 SHALL ignore we_pl/we_ph while swap_p = 1 (swap wins; byte writes dropped).
REQ-022 SHALL allow both byte writes in the same edge (both halves receive di).
REQ-023 SHALL allow ip_inc concurrent with DP byte writes; the two are independent.
REQ-024 SHALL drive alu_b = DP[7:0] when oe_pl_alu = 0 and oe_ph_alu = 1; DP[15:8] when oe_ph_alu = 0 and oe_pl_alu = 1.
REQ-025 SHALL drive alu_b = 0x00 and alu_b_en = 0 when both oe_pl_alu and oe_ph_alu are 1.
REQ-026 SHALL, when both oe_pl_alu and oe_ph_alu are 0 (illegal), drive alu_b = DP[7:0] | DP[15:8], alu_b_en = 1; bench flags it as error.
REQ-027 SHALL make addr reflect new register value immediately after the updating falling edge.

Reset
REQ-028 SHALL on rst = 0 asynchronously set IP = 0x0000 and DP = 0x0000 regardless of clk.
REQ-029 SHALL during reset drive addr = 0x0000; alu_b/alu_b_en follow REQ-024..026 on reset DP.
REQ-030 SHALL discard any pending increment, swap, or byte write asserted at reset; first update occurs on first falling edge after rst rises.

Structure
REQ-031 SHALL take widths (ADDR_W = 16, DATA_W = 8) and reset vector (0x0000) from shared package ccpu_pkg.
REQ-032 SHALL place the 16-bit wrap-around incrementer in one sub-module, ptr_incr, used for both REQ-017 and REQ-019.
REQ-033 SHALL keep all control inputs at the polarities produced by control_unit outputs, with no inversion at instantiation.

Verification
REQ-034 Reset then 3 edges of ip_inc = 1 -> IP = 0x0003, DP = 0x0000, addr = 0x0003 with addr_dp = 0.
REQ-035 di = 0x34 with we_pl = 0, then di = 0x12 with we_ph = 0 -> DP = 0x1234; addr_dp = 1 -> addr = 0x1234.
REQ-036 IP = 0x0010, DP = 0x1234, swap_p = 1 and ip_inc = 1 -> IP = 0x1234, DP = 0x0011.
REQ-037 IP = 0xFFFF, ip_inc = 1 -> IP = 0x0000; swap_p = 1 with we_pl = 0 and di = 0xAA -> byte write dropped, pure swap.
REQ-038 DP = 0xBEEF: oe_pl_alu = 0 -> alu_b = 0xEF; oe_ph_alu = 0 -> alu_b = 0xBE; both high -> alu_b = 0x00, alu_b_en = 0.
REQ-039 rst pulsed low mid-cycle while clk high with IP = 0x1234 -> IP, DP, addr = 0x0000 immediately, no falling edge required.
